// File: rtl/intr_ctrl_n.sv
// intr_ctrl_n -- multi-source interrupt controller in front of the CU interrupt input.
//
// Each external source is synchronised and latched into a pending bit.
// Latching is either on the rising edge or on the level, chosen per source.
// The pending bits are gated by the mask register. If the CU global I flag is set,
// the lowest-index eligible source is granted: its index and vector are frozen and
// a request is raised towards the CU.
// The request/ack/eoi handshake is single level (no nesting).
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   src_in[NUM_SRC]      asynchronous interrupt sources
//   edge_mode[NUM_SRC]   1 = rising-edge latched, 0 = level latched
//   int_en               CU global interrupt enable (I flag)
//   mask_wr, mask_din    load the mask register (1 = source enabled)
//   mask_q, pend_q       current mask and pending registers
//   int_req              registered request to the CU
//   int_ack              one-cycle acknowledge from the CU interrupt state
//   eoi                  one-cycle end-of-interrupt on RETI execute
//   vec, vec_id          vector and index of the granted source
//   in_service           handler currently active
module intr_ctrl_n #(
    parameter int                NUM_SRC     = 8,
    parameter int                VEC_W       = 10,
    parameter logic [VEC_W-1:0]  VEC_BASE    = 10'h3F0,
    parameter int                SYNC_STAGES = 2,
    localparam int               ID_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_in,
    input  logic [NUM_SRC-1:0] edge_mode,
    input  logic               int_en,
    input  logic               mask_wr,
    input  logic [NUM_SRC-1:0] mask_din,
    output logic [NUM_SRC-1:0] mask_q,
    output logic [NUM_SRC-1:0] pend_q,
    output logic               int_req,
    input  logic               int_ack,
    input  logic               eoi,
    output logic [VEC_W-1:0]   vec,
    output logic [ID_W-1:0]    vec_id,
    output logic               in_service
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SERVICE
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] sync_out;
    logic [NUM_SRC-1:0] src_evt;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr_s;
    logic [NUM_SRC-1:0] pend_d;
    logic [ID_W-1:0]    winner;
    logic               ack_clr;

    logic               int_req_q, int_req_d;
    logic               in_service_q, in_service_d;
    logic [ID_W-1:0]    vec_id_q, vec_id_d;
    logic [VEC_W-1:0]   vec_q, vec_d;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Edge sources fire once per rising edge of the synchronised input.
    // Level sources fire every cycle while the input is high.
    // Both the chain and the edge history clear on reset.
    // A source that is already high when reset is released therefore gives one edge.
    assign src_evt  = (edge_mode & sync_out & ~prev_q) | (~edge_mode & sync_out);
    assign eligible = pend_q & mask_q;

    // A set and a clear on the same bit in the same cycle keep the bit set.
    // This way a new event is never lost behind an acknowledge.
    assign clr_s  = ack_clr ? (NUM_SRC'(1) << vec_id_q) : '0;
    assign pend_d = (pend_q & ~clr_s) | src_evt;

    // Per-source synchroniser chain plus the previous synchronised value for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], src_in};
            prev_q <= sync_out;
        end
    end

    // Fixed-priority encoder: scanning from the top down leaves the lowest set index as winner.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    // Handshake FSM.
    // The winner is frozen from grant until the handler ends.
    // In WAIT, the acknowledge takes precedence over withdrawing the request.
    always_comb begin
        state_d      = state_q;
        int_req_d    = int_req_q;
        in_service_d = in_service_q;
        vec_id_d     = vec_id_q;
        vec_d        = vec_q;
        ack_clr      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((|eligible) && int_en) begin
                    vec_id_d  = winner;
                    vec_d     = VEC_BASE + VEC_W'(winner);
                    int_req_d = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (int_ack) begin
                    ack_clr      = 1'b1;
                    int_req_d    = 1'b0;
                    in_service_d = 1'b1;
                    state_d      = S_SERVICE;
                end else if (!int_en || !mask_q[vec_id_q]) begin
                    int_req_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_SERVICE: begin
                if (eoi) begin
                    in_service_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                int_req_d    = 1'b0;
                in_service_d = 1'b0;
                state_d      = S_IDLE;
            end
        endcase
    end

    // State, handshake outputs, pending and mask registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            int_req_q    <= 1'b0;
            in_service_q <= 1'b0;
            vec_id_q     <= '0;
            vec_q        <= VEC_BASE;
            pend_q       <= '0;
            mask_q       <= '0;
        end else begin
            state_q      <= state_d;
            int_req_q    <= int_req_d;
            in_service_q <= in_service_d;
            vec_id_q     <= vec_id_d;
            vec_q        <= vec_d;
            pend_q       <= pend_d;
            if (mask_wr) begin
                mask_q <= mask_din;
            end
        end
    end

    assign int_req    = int_req_q;
    assign in_service = in_service_q;
    assign vec_id     = vec_id_q;
    assign vec        = vec_q;

endmodule

// File: tb/tb_intr_ctrl_n.sv
// tb_intr_ctrl_n -- self-checking bench for intr_ctrl_n.
//
// The bench runs directed scenarios followed by a randomised phase.
// Every cycle, all outputs are compared with a behavioural model of the controller.
// The model keeps the source history as an array and tracks request/service as two flags.
module tb_intr_ctrl_n;

    localparam int          N  = 8;
    localparam int          VW = 10;
    localparam int          SS = 2;
    localparam logic [9:0]  VB = 10'h3F0;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  src_in;
    logic [N-1:0]  edge_mode;
    logic          int_en;
    logic          mask_wr;
    logic [N-1:0]  mask_din;
    logic [N-1:0]  mask_q;
    logic [N-1:0]  pend_q;
    logic          int_req;
    logic          int_ack;
    logic          eoi;
    logic [VW-1:0] vec;
    logic [2:0]    vec_id;
    logic          in_service;

    int    compared   = 0;
    int    mismatched = 0;
    string phase      = "init";

    // Reference model state.
    bit [N-1:0] mHist [SS];
    bit [N-1:0] mPrev;
    bit [N-1:0] mPend;
    bit [N-1:0] mMask;
    bit         mReq;
    bit         mSvc;
    int         mId;

    always #5 clk = ~clk;

    intr_ctrl_n #(
        .NUM_SRC    (N),
        .VEC_W      (VW),
        .VEC_BASE   (VB),
        .SYNC_STAGES(SS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .src_in    (src_in),
        .edge_mode (edge_mode),
        .int_en    (int_en),
        .mask_wr   (mask_wr),
        .mask_din  (mask_din),
        .mask_q    (mask_q),
        .pend_q    (pend_q),
        .int_req   (int_req),
        .int_ack   (int_ack),
        .eoi       (eoi),
        .vec       (vec),
        .vec_id    (vec_id),
        .in_service(in_service)
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advances the model by one clock edge, using the inputs as they stand at that edge.
    task automatic modelStep();
        bit [N-1:0] syncOut;
        bit [N-1:0] ev;
        bit [N-1:0] elig;
        bit [N-1:0] clr;
        int         win;
        clr = '0;
        win = -1;
        if (reset) begin
            for (int i = 0; i < SS; i++) mHist[i] = '0;
            mPrev = '0;
            mPend = '0;
            mMask = '0;
            mReq  = 1'b0;
            mSvc  = 1'b0;
            mId   = 0;
            return;
        end
        syncOut = mHist[SS-1];
        for (int k = 0; k < N; k++)
            ev[k] = edge_mode[k] ? (syncOut[k] && !mPrev[k]) : syncOut[k];
        elig = mPend & mMask;
        for (int k = 0; k < N; k++) begin
            if (elig[k]) begin
                win = k;
                break;
            end
        end
        if (mSvc) begin
            if (eoi) mSvc = 1'b0;
        end else if (mReq) begin
            if (int_ack) begin
                clr[mId] = 1'b1;
                mReq = 1'b0;
                mSvc = 1'b1;
            end else if (!int_en || !mMask[mId]) begin
                mReq = 1'b0;
            end
        end else if (win >= 0 && int_en) begin
            mId  = win;
            mReq = 1'b1;
        end
        mPend = (mPend & ~clr) | ev;
        if (mask_wr) mMask = mask_din;
        mPrev = syncOut;
        for (int i = SS - 1; i > 0; i--) mHist[i] = mHist[i-1];
        mHist[0] = src_in;
    endtask

    task automatic checkOutput();
        cmp({phase, ".mask_q"},     32'(mask_q),     32'(mMask));
        cmp({phase, ".pend_q"},     32'(pend_q),     32'(mPend));
        cmp({phase, ".int_req"},    32'(int_req),    32'(mReq));
        cmp({phase, ".in_service"}, 32'(in_service), 32'(mSvc));
        cmp({phase, ".vec_id"},     32'(vec_id),     32'(mId));
        cmp({phase, ".vec"},        32'(vec),        32'(VB) + 32'(mId));
    endtask

    // Runs the given number of clock cycles.
    // After each cycle it checks the outputs and drops the one-cycle pulses.
    task automatic applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            modelStep();
            #1;
            checkOutput();
            mask_wr = 1'b0;
            int_ack = 1'b0;
            eoi     = 1'b0;
        end
    endtask

    task automatic waitReq(input string tag);
        int n;
        n = 0;
        while (int_req !== 1'b1 && n < 40) begin
            applyStimulus(1);
            n++;
        end
        cmp({tag, ".req_seen"}, 32'(int_req), 32'd1);
    endtask

    initial begin
        int lat;

        reset     = 1'b1;
        src_in    = 8'hFF;
        edge_mode = 8'hFF;
        int_en    = 1'b0;
        mask_wr   = 1'b0;
        mask_din  = '0;
        int_ack   = 1'b0;
        eoi       = 1'b0;

        // Reset with every source high and everything masked.
        phase = "reset";
        applyStimulus(3);
        cmp("reset.vec_const", 32'(vec), 32'h3F0);
        cmp("reset.int_req_const", 32'(int_req), 32'd0);
        cmp("reset.mask_const", 32'(mask_q), 32'd0);
        reset  = 1'b0;
        int_en = 1'b1;
        phase  = "masked_fill";
        applyStimulus(5);
        cmp("masked_fill.pend_const", 32'(pend_q), 32'hFF);
        cmp("masked_fill.no_req", 32'(int_req), 32'd0);

        // Start from a clean state for the directed scenarios.
        reset  = 1'b1;
        src_in = '0;
        phase  = "reset2";
        applyStimulus(3);
        reset    = 1'b0;
        mask_wr  = 1'b1;
        mask_din = 8'hFF;
        phase    = "src3";
        applyStimulus(1);

        // Single edge on source 3: latency, vector, ack and eoi.
        src_in = 8'h08;
        lat = 0;
        while (int_req !== 1'b1 && lat < 20) begin
            applyStimulus(1);
            lat++;
        end
        cmp("src3.latency", 32'(lat), 32'd4);
        cmp("src3.vec_id_const", 32'(vec_id), 32'd3);
        cmp("src3.vec_const", 32'(vec), 32'h3F3);
        src_in  = '0;
        int_ack = 1'b1;
        applyStimulus(1);
        cmp("src3.pend3_cleared", 32'(pend_q[3]), 32'd0);
        cmp("src3.in_service", 32'(in_service), 32'd1);
        applyStimulus(2);
        eoi = 1'b1;
        applyStimulus(1);
        cmp("src3.eoi_idle", 32'(in_service), 32'd0);

        // Simultaneous edges on sources 2 and 5.
        phase  = "src2_5";
        src_in = 8'h24;
        waitReq("src2_5.first");
        cmp("src2_5.first_id", 32'(vec_id), 32'd2);
        cmp("src2_5.first_vec", 32'(vec), 32'h3F2);
        src_in  = '0;
        int_ack = 1'b1;
        applyStimulus(2);
        eoi = 1'b1;
        applyStimulus(1);
        waitReq("src2_5.second");
        cmp("src2_5.second_id", 32'(vec_id), 32'd5);
        cmp("src2_5.second_vec", 32'(vec), 32'h3F5);
        int_ack = 1'b1;
        applyStimulus(2);
        eoi = 1'b1;
        applyStimulus(2);
        cmp("src2_5.pend_empty", 32'(pend_q), 32'd0);

        // Masked source keeps its pending bit, then the mask is opened.
        phase    = "mask5";
        mask_wr  = 1'b1;
        mask_din = 8'hDF;
        applyStimulus(1);
        src_in = 8'h20;
        applyStimulus(5);
        cmp("mask5.pend5", 32'(pend_q[5]), 32'd1);
        cmp("mask5.no_req", 32'(int_req), 32'd0);
        src_in   = '0;
        mask_wr  = 1'b1;
        mask_din = 8'hFF;
        applyStimulus(1);
        applyStimulus(1);
        cmp("mask5.req_after_load", 32'(int_req), 32'd1);
        cmp("mask5.vec_id", 32'(vec_id), 32'd5);
        int_ack = 1'b1;
        applyStimulus(1);
        eoi = 1'b1;
        applyStimulus(1);

        // Level-mode source 1 held high, then dropped before the ack.
        phase     = "level1";
        edge_mode = 8'h00;
        src_in    = 8'h02;
        waitReq("level1.first");
        cmp("level1.first_id", 32'(vec_id), 32'd1);
        int_ack = 1'b1;
        applyStimulus(3);
        eoi = 1'b1;
        applyStimulus(1);
        waitReq("level1.again");
        cmp("level1.again_id", 32'(vec_id), 32'd1);
        src_in = '0;
        applyStimulus(4);
        int_ack = 1'b1;
        applyStimulus(3);
        eoi = 1'b1;
        applyStimulus(6);
        cmp("level1.no_rereq", 32'(int_req), 32'd0);
        cmp("level1.pend_empty", 32'(pend_q), 32'd0);

        // Withdrawal in WAIT when int_en drops, then the request is reissued.
        phase     = "inten";
        edge_mode = 8'hFF;
        src_in    = 8'h10;
        waitReq("inten.first");
        int_en = 1'b0;
        applyStimulus(1);
        cmp("inten.req_dropped", 32'(int_req), 32'd0);
        cmp("inten.pend_kept", 32'(pend_q[4]), 32'd1);
        int_en = 1'b1;
        applyStimulus(1);
        cmp("inten.reissued", 32'(int_req), 32'd1);
        cmp("inten.vec_id", 32'(vec_id), 32'd4);
        src_in  = '0;
        int_ack = 1'b1;
        applyStimulus(1);

        // Reset during SERVICE.
        phase = "svc_reset";
        cmp("svc_reset.in_service_before", 32'(in_service), 32'd1);
        reset = 1'b1;
        applyStimulus(1);
        cmp("svc_reset.in_service", 32'(in_service), 32'd0);
        cmp("svc_reset.pend", 32'(pend_q), 32'd0);
        cmp("svc_reset.mask", 32'(mask_q), 32'd0);
        reset = 1'b0;

        // Randomised traffic against the model.
        phase = "random";
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) src_in = N'($urandom);
            if ($urandom_range(0, 15) == 0) edge_mode = N'($urandom);
            int_en   = ($urandom_range(0, 9) != 0);
            mask_wr  = ($urandom_range(0, 11) == 0);
            mask_din = N'($urandom);
            int_ack  = ($urandom_range(0, 4) == 0);
            eoi      = ($urandom_range(0, 5) == 0);
            reset    = ($urandom_range(0, 149) == 0);
            applyStimulus(1);
        end
        reset = 1'b0;

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
